// File: rtl/controle_irrigacao_fsm.sv
// Irrigation sequencing controller: owns inlet valve, sprinkler and drip valve,
// sequences fill / irrigate / rest from synchronized sensors and a 1 s tick,
// and reports fault, alarm, state code and remaining seconds.
module controle_irrigacao_fsm #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned BS_TIME      = 30,
  parameter int unsigned VS_TIME      = 60,
  parameter int unsigned PAUSE_TIME   = 10,
  parameter int unsigned FILL_TIMEOUT = 120,
  parameter int unsigned ERR_CLEAR    = 3
) (
  input  logic       clk,
  input  logic       reiniciar,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       Ua,
  input  logic       Us,
  input  logic       T,
  output logic       Ve,
  output logic       Bs,
  output logic       Vs,
  output logic       Erro,
  output logic       Alarme,
  output logic [2:0] estado,
  output logic [7:0] seg_restantes
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENCHER   = 3'd1,
    ASPERSAO = 3'd2,
    GOTEJO   = 3'd3,
    PAUSA    = 3'd4,
    ERRO     = 3'd5
  } state_t;

  localparam int unsigned     PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]      BS_T      = 8'(BS_TIME);
  localparam logic [7:0]      VS_T      = 8'(VS_TIME);
  localparam logic [7:0]      PAUSE_T   = 8'(PAUSE_TIME);
  localparam logic [7:0]      FILL_T    = 8'(FILL_TIMEOUT);
  localparam logic [7:0]      ERR_LIM   = 8'(ERR_CLEAR);

  // Sensor vector order: {H, M, L, Ua, Us, T}
  logic [5:0]    sync1_q, sync2_q;
  logic          sH, sM, sL, sUa, sUs, sT;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  state_t        state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          lvl_valid, lvl_empty, timed_d;
  logic          ve_q, bs_q, vs_q, erro_q, alarme_q;
  logic [7:0]    seg_q;

  // Two-flop synchronizers for all six asynchronous sensor inputs
  always_ff @(posedge clk or negedge reiniciar) begin
    if (!reiniciar) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {H, M, L, Ua, Us, T};
      sync2_q <= sync1_q;
    end
  end

  assign {sH, sM, sL, sUa, sUs, sT} = sync2_q;

  // Tank level decode: thermometer codes only; 000 means empty
  always_comb begin
    lvl_empty = ({sH, sM, sL} == 3'b000);
    lvl_valid = ({sH, sM, sL} == 3'b000) || ({sH, sM, sL} == 3'b001) ||
                ({sH, sM, sL} == 3'b011) || ({sH, sM, sL} == 3'b111);
  end

  // Free-running 1 s prescaler next value, never re-phased by the FSM
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (presc_q == PRESC_MAX) presc_d = '0;
  end

  assign tick = (presc_q == PRESC_MAX);

  // Prescaler register
  always_ff @(posedge clk or negedge reiniciar) begin
    if (!reiniciar) presc_q <= '0;
    else            presc_q <= presc_d;
  end

  // Next-state, timer and fault-recovery counter logic
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    err_cnt_d = err_cnt_q;
    if (state_q != ERRO && !lvl_valid) begin
      state_d   = ERRO;
      timer_d   = '0;
      err_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          timer_d = '0;
          if (lvl_empty) begin
            state_d = ENCHER;
            timer_d = FILL_T;
          end else if (!sUs && (!sUa || sT)) begin
            state_d = ASPERSAO;
            timer_d = BS_T;
          end else if (!sUs) begin
            state_d = GOTEJO;
            timer_d = VS_T;
          end
        end
        ENCHER: begin
          if (sH) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (tick) begin
            if (timer_q <= 8'd1) begin
              state_d   = ERRO;
              timer_d   = '0;
              err_cnt_d = '0;
            end else begin
              timer_d = timer_q - 8'd1;
            end
          end
        end
        ASPERSAO, GOTEJO: begin
          if (lvl_empty) begin
            state_d = ENCHER;
            timer_d = FILL_T;
          end else if (sUs) begin
            state_d = PAUSA;
            timer_d = PAUSE_T;
          end else if (tick) begin
            if (timer_q <= 8'd1) begin
              state_d = PAUSA;
              timer_d = PAUSE_T;
            end else begin
              timer_d = timer_q - 8'd1;
            end
          end
        end
        PAUSA: begin
          if (tick) begin
            if (timer_q <= 8'd1) begin
              state_d = IDLE;
              timer_d = '0;
            end else begin
              timer_d = timer_q - 8'd1;
            end
          end
        end
        ERRO: begin
          timer_d = '0;
          if (!lvl_valid) begin
            err_cnt_d = '0;
          end else if (tick) begin
            // Leave on the tick that brings the count to ERR_CLEAR
            if (err_cnt_q + 8'd1 == ERR_LIM) begin
              state_d   = IDLE;
              err_cnt_d = '0;
            end else begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          timer_d   = '0;
          err_cnt_d = '0;
        end
      endcase
    end
  end

  // States whose timer value is shown on the display
  always_comb begin
    timed_d = (state_d == ENCHER) || (state_d == ASPERSAO) ||
              (state_d == GOTEJO) || (state_d == PAUSA);
  end

  // State, timer and counter registers
  always_ff @(posedge clk or negedge reiniciar) begin
    if (!reiniciar) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Registered outputs decoded from the next state so they align with estado
  always_ff @(posedge clk or negedge reiniciar) begin
    if (!reiniciar) begin
      ve_q     <= 1'b0;
      bs_q     <= 1'b0;
      vs_q     <= 1'b0;
      erro_q   <= 1'b0;
      alarme_q <= 1'b0;
      seg_q    <= '0;
    end else begin
      ve_q     <= (state_d == ENCHER);
      bs_q     <= (state_d == ASPERSAO);
      vs_q     <= (state_d == GOTEJO);
      erro_q   <= (state_d == ERRO);
      alarme_q <= (state_d == ERRO) || lvl_empty;
      seg_q    <= timed_d ? timer_d : '0;
    end
  end

  assign Ve            = ve_q;
  assign Bs            = bs_q;
  assign Vs            = vs_q;
  assign Erro          = erro_q;
  assign Alarme        = alarme_q;
  assign estado        = state_q;
  assign seg_restantes = seg_q;

endmodule

// File: tb/tb_controle_irrigacao_fsm.sv
// Directed bench for controle_irrigacao_fsm with short timing parameters.
// Cycle k = k-th rising edge after reset release; ticks occur at k = 4, 8, 12, ...
module tb_controle_irrigacao_fsm;

  logic       clk = 1'b0;
  logic       reiniciar;
  logic       H, M, L, Ua, Us, T;
  logic       Ve, Bs, Vs, Erro, Alarme;
  logic [2:0] estado;
  logic [7:0] seg_restantes;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  controle_irrigacao_fsm #(
    .TICK_DIV    (4),
    .BS_TIME     (5),
    .VS_TIME     (6),
    .PAUSE_TIME  (2),
    .FILL_TIMEOUT(3),
    .ERR_CLEAR   (3)
  ) dut (
    .clk          (clk),
    .reiniciar    (reiniciar),
    .H            (H),
    .M            (M),
    .L            (L),
    .Ua           (Ua),
    .Us           (Us),
    .T            (T),
    .Ve           (Ve),
    .Bs           (Bs),
    .Vs           (Vs),
    .Erro         (Erro),
    .Alarme       (Alarme),
    .estado       (estado),
    .seg_restantes(seg_restantes)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_out(input string tag, input int unsigned est, input int unsigned ve,
                           input int unsigned bs, input int unsigned vs, input int unsigned er,
                           input int unsigned al, input int unsigned seg);
    check_eq({tag, ".estado"}, 32'(estado), est);
    check_eq({tag, ".Ve"}, 32'(Ve), ve);
    check_eq({tag, ".Bs"}, 32'(Bs), bs);
    check_eq({tag, ".Vs"}, 32'(Vs), vs);
    check_eq({tag, ".Erro"}, 32'(Erro), er);
    check_eq({tag, ".Alarme"}, 32'(Alarme), al);
    check_eq({tag, ".seg"}, 32'(seg_restantes), seg);
  endtask

  task automatic set_in(input logic [2:0] hml, input logic ua, input logic us, input logic t);
    {H, M, L} = hml;
    Ua = ua;
    Us = us;
    T  = t;
  endtask

  // Advance to 1 ns after rising edge k
  task automatic wait_to(input int unsigned k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic start_reset(input logic [2:0] hml, input logic ua, input logic us, input logic t);
    reiniciar = 1'b0;
    set_in(hml, ua, us, t);
    #12;
    check_out("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reiniciar = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(3'b111, 1'b0, 1'b1, 1'b0);

    // Sprinkler cycle; sync flops reset to 000, so the FSM briefly fills first
    start_reset(3'b111, 1'b0, 1'b1, 1'b0);
    wait_to(1);  check_out("A.boot_fill", 1, 1, 0, 0, 0, 1, 3);
    wait_to(3);  check_out("A.idle", 0, 0, 0, 0, 0, 0, 0);
    wait_to(4);  set_in(3'b001, 1'b0, 1'b0, 1'b0);
    wait_to(6);  check_out("A.latency", 0, 0, 0, 0, 0, 0, 0);
    wait_to(7);  check_out("A.bs_on", 2, 0, 1, 0, 0, 0, 5);
    for (int unsigned k = 8; k <= 23; k++) begin
      wait_to(k);
      check_eq("A.bs_estado", 32'(estado), 2);
      check_eq("A.bs_seg", 32'(seg_restantes), 6 - k / 4);
    end
    wait_to(24); check_out("A.pause", 4, 0, 0, 0, 0, 0, 2);
    wait_to(28); check_out("A.pause1", 4, 0, 0, 0, 0, 0, 1);
    wait_to(32); check_out("A.idle2", 0, 0, 0, 0, 0, 0, 0);
    wait_to(33); check_out("A.bs_again", 2, 0, 1, 0, 0, 0, 5);

    // Asynchronous reset in the middle of a sprinkler run
    #2 reiniciar = 1'b0;
    #1 check_out("A.async_rst", 0, 0, 0, 0, 0, 0, 0);
    set_in(3'b111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reiniciar = 1'b1;
    cyc = 0;
    wait_to(3);  check_out("A.rst_idle", 0, 0, 0, 0, 0, 0, 0);
    wait_to(4);  check_out("A.rst_bs", 2, 0, 1, 0, 0, 0, 5);
    wait_to(8);  check_eq("A.rst_bs_seg", 32'(seg_restantes), 4);
    set_in(3'b110, 1'b0, 1'b0, 1'b0);
    wait_to(10); check_out("A.inv_pending", 2, 0, 1, 0, 0, 0, 4);
    wait_to(11); check_out("A.inv_erro", 5, 0, 0, 0, 1, 1, 0);

    // Drip run, stopped by wet soil; then sprinkler chosen by heat and held
    start_reset(3'b111, 1'b1, 1'b1, 1'b0);
    wait_to(4);  check_out("B.idle", 0, 0, 0, 0, 0, 0, 0);
    set_in(3'b011, 1'b1, 1'b0, 1'b0);
    wait_to(7);  check_out("B.vs_on", 3, 0, 0, 1, 0, 0, 6);
    wait_to(8);  check_eq("B.vs_seg", 32'(seg_restantes), 5);
    wait_to(9);  Us = 1'b1;
    wait_to(11); check_out("B.vs_hold", 3, 0, 0, 1, 0, 0, 5);
    wait_to(12); check_out("B.wet_pause", 4, 0, 0, 0, 0, 0, 2);
    wait_to(16); check_eq("B.pause_seg", 32'(seg_restantes), 1);
    wait_to(20); check_out("B.idle2", 0, 0, 0, 0, 0, 0, 0);
    wait_to(22); check_out("B.idle_wet", 0, 0, 0, 0, 0, 0, 0);
    set_in(3'b011, 1'b1, 1'b0, 1'b1);
    wait_to(25); check_out("B.hot_bs", 2, 0, 1, 0, 0, 0, 5);
    wait_to(26); T = 1'b0;
    wait_to(30); check_out("B.mode_fixed", 2, 0, 1, 0, 0, 0, 4);

    // Fill until high level, then fill timeout into ERRO and recovery
    start_reset(3'b111, 1'b1, 1'b1, 1'b0);
    wait_to(4);  set_in(3'b000, 1'b1, 1'b1, 1'b0);
    wait_to(6);  check_out("C.pre_fill", 0, 0, 0, 0, 0, 0, 0);
    wait_to(7);  check_out("C.fill", 1, 1, 0, 0, 0, 1, 3);
    wait_to(8);  check_eq("C.fill_seg", 32'(seg_restantes), 2);
    {H, M, L} = 3'b001;
    wait_to(9);  {H, M, L} = 3'b011;
    wait_to(10); {H, M, L} = 3'b111;
    wait_to(11); check_out("C.fill_mid", 1, 1, 0, 0, 0, 0, 2);
    wait_to(12); check_out("C.fill_dec", 1, 1, 0, 0, 0, 0, 1);
    wait_to(13); check_out("C.full", 0, 0, 0, 0, 0, 0, 0);
    {H, M, L} = 3'b000;
    wait_to(16); check_out("C.fill2", 1, 1, 0, 0, 0, 1, 3);
    wait_to(17); {H, M, L} = 3'b001;
    wait_to(20); check_eq("C.fill2_seg2", 32'(seg_restantes), 2);
    wait_to(24); check_eq("C.fill2_seg1", 32'(seg_restantes), 1);
    wait_to(27); check_out("C.fill2_last", 1, 1, 0, 0, 0, 0, 1);
    wait_to(28); check_out("C.timeout", 5, 0, 0, 0, 1, 1, 0);
    wait_to(39); check_eq("C.erro_hold", 32'(estado), 5);
    wait_to(40); check_out("C.recover", 0, 0, 0, 0, 0, 0, 0);

    // Invalid level into ERRO; a glitch restarts the clear count
    start_reset(3'b111, 1'b1, 1'b1, 1'b0);
    wait_to(4);  {H, M, L} = 3'b101;
    wait_to(6);  check_eq("D.pre_inv", 32'(estado), 0);
    wait_to(7);  check_out("D.inv", 5, 0, 0, 0, 1, 1, 0);
    wait_to(9);  {H, M, L} = 3'b011;
    wait_to(17); {H, M, L} = 3'b101;
    wait_to(18); {H, M, L} = 3'b011;
    wait_to(20); check_out("D.glitch_hold", 5, 0, 0, 0, 1, 1, 0);
    wait_to(31); check_out("D.count_hold", 5, 0, 0, 0, 1, 1, 0);
    wait_to(32); check_out("D.clear", 0, 0, 0, 0, 0, 0, 0);

    // Random sensor activity: valve exclusivity and Erro/state consistency
    start_reset(3'b111, 1'b1, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 20000; i++) begin
      wait_to(cyc + 1);
      if ($urandom_range(0, 7) == 0) {H, M, L, Ua, Us, T} = 6'($urandom);
      check_eq("R.valves", 32'((32'(Ve) + 32'(Bs) + 32'(Vs)) <= 1), 1);
      check_eq("R.erro_state", 32'(Erro), 32'(estado == 3'd5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
